uart_cmd_ctrl: RTL and testbench

Packet-level command controller behind the UART receiver. Consumes the receiver's byte stream (`data_out` / `data_ready`), frames it into command packets, and verifies each packet's checksum. Only after a packet checks good does it replay the buffered payload as register-file write strobes. It sequences everything between the serial byte source and the on-chip register bus, and reports good and bad packets to the status logic.

---
 rtl/uart_cmd_pkg.sv | 23 ++
 rtl/uart_cmd_ctrl_if.sv | 25 ++
 rtl/uart_cmd_buf.sv | 28 ++
 rtl/uart_cmd_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and constants for the UART command controller
// Purpose: FSM state encoding, the single legal command opcode and the error codes
//          reported on err_code.
// Ports:   none (package).
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        HUNT,
        CMD,
        ADDR,
        LEN,
        PAYLOAD,
        CHK,
        COMMIT
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h01;

    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_FMT = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - byte-source and register-write bundle of the command controller
// Purpose: groups the receiver byte input, the register write strobe and the status outputs.
// Ports:   master - byte source / register-file side (drives rx_data, rx_valid)
//          slave  - the controller (drives write strobe, pkt_ok, pkt_err, err_code, busy)
interface uart_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       reg_wr_en;
    logic [7:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output rx_data, rx_valid,
        input  reg_wr_en, reg_wr_addr, reg_wr_data, pkt_ok, pkt_err, err_code, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output reg_wr_en, reg_wr_addr, reg_wr_data, pkt_ok, pkt_err, err_code, busy
    );
endinterface

// File: rtl/uart_cmd_buf.sv
// rtl/uart_cmd_buf.sv - payload staging buffer for the UART command controller
// Purpose: DEPTH x 8 register array holding a packet's payload until its checksum is known.
// Ports:   clk                 - clock
//          wr_en_i/wr_addr_i/wr_data_i - synchronous write port
//          rd_addr_i/rd_data_o - combinational read port
module uart_cmd_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - packet framer, checksum verifier and register-write sequencer
// Purpose: frames SYNC/CMD/ADDR/LEN/payload/CHK packets from the receiver byte stream,
//          buffers the payload and replays it as register writes once the XOR checksum
//          matches; aborts on bad opcode/length, bad checksum or inter-byte timeout.
// Ports:   clk - clock
//          rst - synchronous active-high reset
//          bus - uart_cmd_ctrl_if.slave: rx_data/rx_valid in; reg_wr_*, pkt_ok, pkt_err,
//                err_code, busy out (all registered)
module uart_cmd_ctrl #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          MAX_LEN        = 16,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd312510
) (
    input logic            clk,
    input logic            rst,
    uart_cmd_ctrl_if.slave bus
);
    import uart_cmd_pkg::*;

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t      state_q, state_d;
    logic        rx_valid_q;
    logic        stb_q;
    logic [7:0]  data_q;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  xor_q, xor_d;
    logic [19:0] tmo_q, tmo_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic        busy_q;

    logic        byte_stb;
    logic        counting;
    logic        tmo_hit;
    logic        abort;
    logic [1:0]  abort_code;
    logic        buf_we;
    logic [7:0]  buf_rd;

    // The receiver level and byte are registered first; the strobe is the registered
    // rising edge, so the FSM sees a byte one cycle after rx_valid rises.
    assign byte_stb = stb_q;

    uart_cmd_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (buf_we),
        .wr_addr_i (idx_q[AW-1:0]),
        .wr_data_i (data_q),
        .rd_addr_i (idx_q[AW-1:0]),
        .rd_data_o (buf_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            rx_valid_q <= 1'b0;
            stb_q      <= 1'b0;
            data_q     <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            xor_q      <= '0;
            tmo_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= bus.rx_valid;
            stb_q      <= bus.rx_valid & ~rx_valid_q;
            data_q     <= bus.rx_data;
            addr_q     <= addr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            xor_q      <= xor_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            code_q     <= code_d;
            busy_q     <= (state_d != HUNT);
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        xor_d      = xor_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        code_d     = code_q;
        buf_we     = 1'b0;
        abort      = 1'b0;
        abort_code = ERR_FMT;

        counting = (state_q == CMD) || (state_q == ADDR) || (state_q == LEN) ||
                   (state_q == PAYLOAD) || (state_q == CHK);
        // A byte arriving on the expiry cycle clears the counter instead of timing out.
        tmo_d    = (counting && !byte_stb) ? tmo_q + 20'd1 : 20'd0;
        tmo_hit  = counting && !byte_stb && (tmo_q == TIMEOUT_CYCLES);

        if (tmo_hit) begin
            abort      = 1'b1;
            abort_code = ERR_TMO;
        end else begin
            case (state_q)
                HUNT: begin
                    idx_d = '0;
                    xor_d = '0;
                    if (byte_stb && data_q == SYNC_BYTE) begin
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (byte_stb) begin
                        if (data_q == CMD_WRITE) begin
                            xor_d   = xor_q ^ data_q;
                            state_d = ADDR;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (byte_stb) begin
                        addr_d  = data_q;
                        xor_d   = xor_q ^ data_q;
                        state_d = LEN;
                    end
                end
                LEN: begin
                    if (byte_stb) begin
                        len_d = data_q;
                        xor_d = xor_q ^ data_q;
                        if (data_q > MAX_LEN_B) begin
                            abort = 1'b1;
                        end else if (data_q == 8'd0) begin
                            state_d = CHK;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (byte_stb) begin
                        buf_we = 1'b1;
                        xor_d  = xor_q ^ data_q;
                        idx_d  = idx_q + 8'd1;
                        if (idx_q == len_q - 8'd1) begin
                            idx_d   = '0;
                            state_d = CHK;
                        end
                    end
                end
                CHK: begin
                    if (byte_stb) begin
                        if (data_q == xor_q) begin
                            idx_d   = '0;
                            state_d = COMMIT;
                        end else begin
                            abort      = 1'b1;
                            abort_code = ERR_CHK;
                        end
                    end
                end
                COMMIT: begin
                    // One write per cycle; the cycle after the last write raises pkt_ok.
                    if (idx_q != len_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q + idx_q;
                        wr_data_d = buf_rd;
                        idx_d     = idx_q + 8'd1;
                    end else begin
                        ok_d    = 1'b1;
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (abort) begin
            err_d   = 1'b1;
            code_d  = abort_code;
            state_d = HUNT;
        end
    end

    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_wr_addr = wr_addr_q;
    assign bus.reg_wr_data = wr_data_q;
    assign bus.pkt_ok      = ok_q;
    assign bus.pkt_err     = err_q;
    assign bus.err_code    = code_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard testbench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

    localparam logic [19:0] TMO = 20'd300;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        logic [1:0] kind;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    localparam logic [1:0] K_WR  = 2'd0;
    localparam logic [1:0] K_OK  = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    ev_t  exp_q[$];

    uart_cmd_ctrl_if bus_if ();

    uart_cmd_ctrl #(
        .SYNC_BYTE      (8'hA5),
        .MAX_LEN        (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = K_WR; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_ok();
        ev_t e;
        e.kind = K_OK; e.a = 8'h00; e.d = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic exp_err(input logic [1:0] code);
        ev_t e;
        e.kind = K_ERR; e.a = {6'b0, code}; e.d = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input logic [1:0] kind, input logic [7:0] a, input logic [7:0] d,
                            input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event kind=%0d a=%h d=%h, none expected", name, kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.a !== a || e.d !== d) begin
                errors++;
                $display("FAIL %s: got kind=%0d a=%h d=%h, expected kind=%0d a=%h d=%h",
                         name, kind, a, d, e.kind, e.a, e.d);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every output event is matched against the head of the expectation queue.
    always @(negedge clk) begin
        if (bus_if.reg_wr_en === 1'b1)
            check_ev(K_WR, bus_if.reg_wr_addr, bus_if.reg_wr_data, "write");
        if (bus_if.pkt_ok === 1'b1) begin
            check_ev(K_OK, 8'h00, 8'h00, "pkt_ok");
            check_val("busy_with_ok", {7'b0, bus_if.busy}, 8'h00);
        end
        if (bus_if.pkt_err === 1'b1) begin
            check_ev(K_ERR, {6'b0, bus_if.err_code}, 8'h00, "pkt_err");
            check_val("busy_with_err", {7'b0, bus_if.busy}, 8'h00);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input bytes_t bq);
        foreach (bq[i]) send_byte(bq[i]);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (bus_if.busy === 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_val("idle_reached", {7'b0, bus_if.busy}, 8'h00);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_wr_en"},   {7'b0, bus_if.reg_wr_en}, 8'h00);
        check_val({tag, "_wr_addr"}, bus_if.reg_wr_addr, 8'h00);
        check_val({tag, "_wr_data"}, bus_if.reg_wr_data, 8'h00);
        check_val({tag, "_pkt_ok"},  {7'b0, bus_if.pkt_ok}, 8'h00);
        check_val({tag, "_pkt_err"}, {7'b0, bus_if.pkt_err}, 8'h00);
        check_val({tag, "_err_code"}, {6'b0, bus_if.err_code}, 8'h00);
        check_val({tag, "_busy"},    {7'b0, bus_if.busy}, 8'h00);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Garbage before SYNC, then good packet: CHK = 01^10^02^AA^55 = EC
        exp_wr(8'h10, 8'hAA); exp_wr(8'h11, 8'h55); exp_ok();
        send_bytes('{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h10, 8'h02, 8'hAA, 8'h55, 8'hEC});
        wait_idle(50);

        // Address wrap: CHK = 01^FF^02^11^22 = CF
        exp_wr(8'hFF, 8'h11); exp_wr(8'h00, 8'h22); exp_ok();
        send_bytes('{8'hA5, 8'h01, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCF});
        wait_idle(50);

        // Bad checksum, then the good packet again
        exp_err(2'd1);
        send_bytes('{8'hA5, 8'h01, 8'h10, 8'h02, 8'hAA, 8'h55, 8'hED});
        wait_idle(50);
        exp_wr(8'h10, 8'hAA); exp_wr(8'h11, 8'h55); exp_ok();
        send_bytes('{8'hA5, 8'h01, 8'h10, 8'h02, 8'hAA, 8'h55, 8'hEC});
        wait_idle(50);

        // Bad command
        exp_err(2'd2);
        send_bytes('{8'hA5, 8'h02});
        wait_idle(50);

        // LEN 17 exceeds MAX_LEN 16
        exp_err(2'd2);
        send_bytes('{8'hA5, 8'h01, 8'h30, 8'h11});
        wait_idle(50);

        // LEN 0: CHK = 01^40^00 = 41
        exp_ok();
        send_bytes('{8'hA5, 8'h01, 8'h40, 8'h00, 8'h41});
        wait_idle(50);

        // Stall after ADDR
        exp_err(2'd3);
        send_bytes('{8'hA5, 8'h01, 8'h50});
        wait_idle(int'(TMO) + 50);

        // Byte strobe on the expiry cycle: CHK = 01^60^01^7E = 1E
        exp_wr(8'h60, 8'h7E); exp_ok();
        send_bytes('{8'hA5, 8'h01, 8'h60});
        repeat (int'(TMO) - 1) @(negedge clk);
        send_bytes('{8'h01, 8'h7E, 8'h1E});
        wait_idle(50);

        // rx_valid held high: one SYNC counted, then the packet times out once
        exp_err(2'd3);
        @(negedge clk);
        bus_if.rx_data  = 8'hA5;
        bus_if.rx_valid = 1'b1;
        repeat (5000) @(negedge clk);
        bus_if.rx_valid = 1'b0;
        wait_idle(50);

        // Reset right after the first write of a LEN 4 commit: CHK = 01^20^04^01^02^03^04 = 21
        exp_wr(8'h20, 8'h01);
        send_bytes('{8'hA5, 8'h01, 8'h20, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h21});
        n = 0;
        while (bus_if.reg_wr_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("first_commit_write_seen", {7'b0, bus_if.reg_wr_en}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Recovery after reset
        exp_wr(8'h10, 8'hAA); exp_wr(8'h11, 8'h55); exp_ok();
        send_bytes('{8'hA5, 8'h01, 8'h10, 8'h02, 8'hAA, 8'h55, 8'hEC});
        wait_idle(50);

        check_val("events_left", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
